// File: rtl/rom_download_bridge.sv
// Filters the HPS ioctl download stream by ROM index, buffers it and replays it to the
// core ROM port. The core is held in reset until the image is written. Optional: ROM_LOADER_CHECKSUM_EN.
module rom_download_bridge #(
    parameter logic [7:0] ROM_INDEX   = 8'd0,
    parameter int         ADDR_W      = 14,
    parameter int         ROM_SIZE    = 16384,
    parameter int         FIFO_DEPTH  = 4,
    parameter int         WR_GAP      = 2,
    parameter int         HOLD_CYCLES = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [7:0]        ioctl_index,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] dn_addr,
    output logic [7:0]        dn_data,
    output logic              dn_wr,
    output logic              core_reset,
    output logic              rom_ready,
    output logic              dl_overflow,
    output logic [7:0]        dl_checksum
);

    localparam int          PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CNT_W     = PTR_W + 1;
    localparam int          GAP_W     = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;
    localparam int          HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam int          WORD_W    = ADDR_W + 8;
    localparam logic [31:0] ROM_LIMIT = ROM_SIZE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_HOLD,
        S_READY
    } state_t;

    state_t state_q, state_d;

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, count_next;
    logic [GAP_W-1:0]  gap_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    logic              match, in_range, push_req;
    logic              fifo_empty, fifo_full, can_pop;
    logic              push, pop, drop, load_entry;
    logic [WORD_W-1:0] push_word, pop_word;

    assign match      = ioctl_download && (ioctl_index == ROM_INDEX);
    assign in_range   = ({7'd0, ioctl_addr} < ROM_LIMIT);
    assign push_req   = (state_q == S_LOAD) && match && ioctl_wr;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign can_pop    = !fifo_empty && (gap_cnt == '0);

    // A full FIFO still accepts a byte when the same cycle pops one.
    assign push       = push_req && in_range && (!fifo_full || can_pop);
    assign drop       = push_req && !push;

    // An empty FIFO forwards the incoming byte straight to the ROM port.
    assign pop        = (gap_cnt == '0) && (!fifo_empty || push);
    assign push_word  = {ioctl_addr[ADDR_W-1:0], ioctl_dout};
    assign pop_word   = fifo_empty ? push_word : mem[rd_ptr];
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);
    assign load_entry = (state_d == S_LOAD) && (state_q != S_LOAD);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (match) state_d = S_LOAD;
            S_LOAD:  if (!ioctl_download) state_d = S_DRAIN;
            S_DRAIN: begin
                if (match)                             state_d = S_LOAD;
                else if (fifo_empty && gap_cnt == '0) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (match)                                   state_d = S_LOAD;
                else if (hold_cnt >= HOLD_W'(HOLD_CYCLES)) state_d = S_READY;
            end
            S_READY: if (match) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: FIFO storage has no reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk_sys) begin
        if (push) mem[wr_ptr] <= push_word;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            gap_cnt     <= '0;
            hold_cnt    <= '0;
            ioctl_wait  <= 1'b0;
            dn_addr     <= '0;
            dn_data     <= 8'h00;
            dn_wr       <= 1'b0;
            core_reset  <= 1'b1;
            rom_ready   <= 1'b0;
            dl_overflow <= 1'b0;
        end else begin
            state_q    <= state_d;
            count      <= count_next;
            ioctl_wait <= (count_next >= CNT_W'(FIFO_DEPTH - 1));
            dn_wr      <= pop;
            core_reset <= (state_d != S_READY);
            rom_ready  <= (state_d == S_READY);

            if (push) wr_ptr <= wr_ptr + PTR_W'(1);

            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                dn_addr <= pop_word[WORD_W-1:8];
                dn_data <= pop_word[7:0];
                gap_cnt <= GAP_W'(WR_GAP - 1);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end

            // Hold time is measured from the most recent ROM write (or LOAD entry if none).
            if (load_entry || pop)                     hold_cnt <= '0;
            else if (hold_cnt < HOLD_W'(HOLD_CYCLES)) hold_cnt <= hold_cnt + HOLD_W'(1);

            if (load_entry) dl_overflow <= 1'b0;
            else if (drop)  dl_overflow <= 1'b1;
        end
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0] checksum_q;

    always_ff @(posedge clk_sys) begin
        if (reset || load_entry) checksum_q <= 8'h00;
        else if (push)           checksum_q <= checksum_q + ioctl_dout;
    end

    assign dl_checksum = checksum_q;
`else
    assign dl_checksum = 8'h00;
`endif

endmodule

// File: tb/tb_rom_download_bridge.sv
// Directed bench for rom_download_bridge: ordered replay, pacing/back-pressure, range drop,
// index filter, mid-load reset and checksum, with default parameters.
module tb_rom_download_bridge;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = 8'h00;
    logic [7:0]  ioctl_index = 8'h00;
    logic        ioctl_wait;
    logic [13:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic        core_reset;
    logic        rom_ready;
    logic        dl_overflow;
    logic [7:0]  dl_checksum;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_wr_cyc = 0;
    int          ready_rise_cyc = 0;
    logic        rdy_prev = 1'b0;
    logic [21:0] wr_q[$];

    rom_download_bridge dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .ioctl_wait     (ioctl_wait),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_wr          (dn_wr),
        .core_reset     (core_reset),
        .rom_ready      (rom_ready),
        .dl_overflow    (dl_overflow),
        .dl_checksum    (dl_checksum)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc++;

    // Capture ROM writes and the rom_ready rising edge mid-cycle.
    always @(negedge clk_sys) begin
        if (dn_wr) begin
            wr_q.push_back({dn_addr, dn_data});
            last_wr_cyc = cyc;
        end
        if (rom_ready && !rdy_prev) ready_rise_cyc = cyc;
        rdy_prev = rom_ready;
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wr_entry(input int i);
        return (i < wr_q.size()) ? {10'd0, wr_q[i]} : 32'hDEAD_BEEF;
    endfunction

    task automatic wait_ready(input int limit);
        int k = 0;
        while (!rom_ready && k < limit) begin
            tick();
            k++;
        end
        check("ready_reached", {31'd0, rom_ready}, 32'd1);
    endtask

    task automatic write_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    initial begin
        int         sent;
        int         first_wait;
        logic       wait_prev;
        logic [7:0] exp_sum;

        // Reset state
        repeat (3) tick();
        check("rst_wait",     {31'd0, ioctl_wait},  32'd0);
        check("rst_dn_addr",  {18'd0, dn_addr},     32'd0);
        check("rst_dn_data",  {24'd0, dn_data},     32'd0);
        check("rst_dn_wr",    {31'd0, dn_wr},       32'd0);
        check("rst_core_rst", {31'd0, core_reset},  32'd1);
        check("rst_ready",    {31'd0, rom_ready},   32'd0);
        check("rst_ovf",      {31'd0, dl_overflow}, 32'd0);
        check("rst_sum",      {24'd0, dl_checksum}, 32'd0);
        reset = 1'b0;
        tick();

        // 1: 16 paced bytes, data = addr ^ A5; ready 17 cycles after the last write
        wr_q.delete();
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            write_byte(25'(i), 8'(i) ^ 8'hA5);
            repeat (3) tick();
        end
        ioctl_download = 1'b0;
        wait_ready(100);
        tick();
        check("t1_count", wr_q.size(), 32'd16);
        for (int i = 0; i < 16; i++)
            check($sformatf("t1_byte%0d", i), wr_entry(i), {10'd0, 14'(i), 8'(i) ^ 8'hA5});
        check("t1_ready_latency", 32'(ready_rise_cyc - last_wr_cyc), 32'd17);
        check("t1_core_rst", {31'd0, core_reset},  32'd0);
        check("t1_ovf",       {31'd0, dl_overflow}, 32'd0);

        // 6: checksum of FF + 02, entered from READY
        wr_q.delete();
        ioctl_download = 1'b1;
        tick();
        check("t6_entry_ready",    {31'd0, rom_ready},  32'd0);
        check("t6_entry_core_rst", {31'd0, core_reset}, 32'd1);
        write_byte(25'h20, 8'hFF);
        write_byte(25'h21, 8'h02);
        ioctl_download = 1'b0;
        wait_ready(100);
        tick();
`ifdef ROM_LOADER_CHECKSUM_EN
        exp_sum = 8'h01;
`else
        exp_sum = 8'h00;
`endif
        check("t6_count",    wr_q.size(), 32'd2);
        check("t6_byte0",    wr_entry(0), {10'd0, 14'h20, 8'hFF});
        check("t6_byte1",    wr_entry(1), {10'd0, 14'h21, 8'h02});
        check("t6_checksum", {24'd0, dl_checksum}, {24'd0, exp_sum});

        // 3: last in-range address accepted, first out-of-range one dropped
        wr_q.delete();
        ioctl_download = 1'b1;
        tick();
        write_byte(25'h3FFF, 8'h5A);
        write_byte(25'h4000, 8'h77);
        tick();
        check("t3_ovf_set", {31'd0, dl_overflow}, 32'd1);
        ioctl_download = 1'b0;
        wait_ready(100);
        tick();
        check("t3_ovf_sticky", {31'd0, dl_overflow}, 32'd1);
        check("t3_count",      wr_q.size(), 32'd1);
        check("t3_byte0",      wr_entry(0), {10'd0, 14'h3FFF, 8'h5A});

        // 2: source writes every cycle, reacts to ioctl_wait one cycle late
        wr_q.delete();
        ioctl_download = 1'b1;
        tick();
        check("t2_ovf_cleared", {31'd0, dl_overflow}, 32'd0);
        sent       = 0;
        first_wait = -1;
        wait_prev  = 1'b0;
        for (int k = 0; k < 200 && sent < 12; k++) begin
            ioctl_wr   = !wait_prev;
            ioctl_addr = 25'h100 + 25'(sent);
            ioctl_dout = 8'(sent * 7 + 3);
            if (ioctl_wait && first_wait < 0) first_wait = sent;
            wait_prev = ioctl_wait;
            tick();
            if (ioctl_wr) sent++;
        end
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        check("t2_all_sent",  32'(sent), 32'd12);
        check("t2_wait_rise", 32'(first_wait), 32'd6);
        wait_ready(200);
        tick();
        check("t2_count", wr_q.size(), 32'd12);
        for (int i = 0; i < 12; i++)
            check($sformatf("t2_byte%0d", i), wr_entry(i), {10'd0, 14'h100 + 14'(i), 8'(i * 7 + 3)});
        check("t2_ovf", {31'd0, dl_overflow}, 32'd0);

        // 5: reset while two bytes are still buffered
        wr_q.delete();
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'h40 + 25'(i);
            ioctl_dout = 8'h10 + 8'(i);
            tick();
        end
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        reset          = 1'b1;
        tick();
        check("t5_dn_wr",     {31'd0, dn_wr},      32'd0);
        check("t5_core_rst",  {31'd0, core_reset}, 32'd1);
        check("t5_ready",     {31'd0, rom_ready},  32'd0);
        check("t5_wait",      {31'd0, ioctl_wait}, 32'd0);
        check("t5_pre_count", wr_q.size(),         32'd2);
        reset = 1'b0;
        repeat (30) tick();
        check("t5_post_count", wr_q.size(),        32'd2);
        check("t5_ready_low",  {31'd0, rom_ready}, 32'd0);

        // 4: download for another index is ignored
        ioctl_index    = 8'd1;
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) write_byte(25'(i), 8'hC0 + 8'(i));
        ioctl_download = 1'b0;
        repeat (30) tick();
        check("t4_count",    wr_q.size(),          32'd2);
        check("t4_ready",    {31'd0, rom_ready},   32'd0);
        check("t4_core_rst", {31'd0, core_reset},  32'd1);
        check("t4_ovf",      {31'd0, dl_overflow}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
